// File: rtl/lane_collision_detector.sv
// Per-frame scan of the obstacle table against the player sprite; emits a
// one-cycle collision pulse and diagnostic status for the HUD and debug LEDs.
module lane_collision_detector #(
   parameter int NUM_OBS  = 8,
   parameter int IDX_W    = 3,
   parameter int Y_W      = 9,
   parameter int PLAYER_Y = 400,
   parameter int PLAYER_H = 20,
   parameter int OBS_H    = 20
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             frame_tick,
   input  logic             freeze,
   input  logic [1:0]       player_lane,
   output logic [IDX_W-1:0] obs_addr,
   input  logic             obs_valid,
   input  logic [1:0]       obs_lane,
   input  logic [Y_W-1:0]   obs_y,
   output logic             busy,
   output logic             collision,
   output logic [IDX_W-1:0] hit_index,
   output logic             scan_overrun
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_OBS - 1);
   // One extra bit so an obstacle near the bottom of the range cannot wrap.
   localparam logic [Y_W:0] ROW_LO   = (Y_W+1)'(PLAYER_Y);
   localparam logic [Y_W:0] ROW_HI   = (Y_W+1)'(PLAYER_Y + PLAYER_H - 1);
   localparam logic [Y_W:0] OBS_SPAN = (Y_W+1)'(OBS_H - 1);

   state_t           state;
   logic [1:0]       lane_q;
   logic             hit_flag;
   logic [IDX_W-1:0] first_idx;
   logic [IDX_W-1:0] cmp_idx;
   logic             cmp_en;
   logic [Y_W:0]     y_top;
   logic [Y_W:0]     y_bot;
   logic             hit_now;

   assign y_top   = {1'b0, obs_y};
   assign y_bot   = y_top + OBS_SPAN;
   assign hit_now = cmp_en && obs_valid && (obs_lane == lane_q) &&
                    (y_top <= ROW_HI) && (y_bot >= ROW_LO);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         obs_addr     <= '0;
         busy         <= 1'b0;
         collision    <= 1'b0;
         hit_index    <= '0;
         scan_overrun <= 1'b0;
         hit_flag     <= 1'b0;
         lane_q       <= '0;
         first_idx    <= '0;
         cmp_idx      <= '0;
         cmp_en       <= 1'b0;
      end else begin
         cmp_en    <= 1'b0;
         collision <= 1'b0;
         // Read data arrives one cycle after the address, so tag it with that address.
         cmp_idx   <= obs_addr;
         if (frame_tick && busy)
            scan_overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (frame_tick && !freeze) begin
                  state    <= SCAN;
                  obs_addr <= '0;
                  lane_q   <= player_lane;
                  hit_flag <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SCAN: begin
               if (freeze) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  obs_addr <= '0;
               end else begin
                  cmp_en <= 1'b1;
                  if (hit_now && !hit_flag)
                     first_idx <= cmp_idx;
                  if (hit_now)
                     hit_flag <= 1'b1;
                  if (obs_addr == LAST_ADDR)
                     state <= DRAIN;
                  else
                     obs_addr <= obs_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (freeze) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  obs_addr <= '0;
               end else begin
                  collision <= hit_flag || hit_now;
                  if (hit_flag)
                     hit_index <= first_idx;
                  else if (hit_now)
                     hit_index <= cmp_idx;
                  hit_flag <= hit_flag || hit_now;
                  busy     <= 1'b0;
                  state    <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lane_collision_detector.sv
// Bench for lane_collision_detector: table vectors, hand-built corner sequences
// and random obstacle tables checked against a slot-by-slot overlap model.
module tb_lane_collision_detector;

   localparam int N  = 8;
   localparam int PY = 400;
   localparam int PH = 20;
   localparam int OH = 20;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       freeze = 1'b0;
   logic [1:0] player_lane = 2'd0;
   logic [2:0] obs_addr;
   logic       obs_valid;
   logic [1:0] obs_lane;
   logic [8:0] obs_y;
   logic       busy;
   logic       collision;
   logic [2:0] hit_index;
   logic       scan_overrun;

   lane_collision_detector dut (
      .Clock(Clock), .Reset(Reset), .frame_tick(frame_tick), .freeze(freeze),
      .player_lane(player_lane), .obs_addr(obs_addr), .obs_valid(obs_valid),
      .obs_lane(obs_lane), .obs_y(obs_y), .busy(busy), .collision(collision),
      .hit_index(hit_index), .scan_overrun(scan_overrun)
   );

   always #5 Clock = ~Clock;

   // Obstacle manager stand-in: synchronous read, one-cycle latency.
   logic       mem_v [N];
   logic [1:0] mem_l [N];
   logic [8:0] mem_y [N];
   always_ff @(posedge Clock) begin
      obs_valid <= mem_v[obs_addr];
      obs_lane  <= mem_l[obs_addr];
      obs_y     <= mem_y[obs_addr];
   end

   int total = 0;
   int bad   = 0;
   int prev_idx = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < N; i++) begin
         mem_v[i] = 1'b0; mem_l[i] = 2'd0; mem_y[i] = 9'd0;
      end
   endtask

   // Reference: which slots overlap the player, by plain integer geometry.
   task automatic model(input int lane, output bit hit, output int idx);
      hit = 1'b0;
      idx = prev_idx;
      for (int i = 0; i < N; i++) begin
         int top, bot;
         top = int'(mem_y[i]);
         bot = top + OH - 1;
         if (mem_v[i] && int'(mem_l[i]) == lane && top <= PY + PH - 1 && bot >= PY && !hit) begin
            hit = 1'b1;
            idx = i;
         end
      end
   endtask

   // Issue one tick and watch cycles T+1..T+12.
   task automatic scan_and_check(input string name, input int lane, input bit exp_hit, input int exp_idx);
      int bmask, cmask;
      bmask = 0; cmask = 0;
      @(posedge Clock); #1;
      player_lane = 2'(lane);
      frame_tick  = 1'b1;
      @(posedge Clock); #1;
      frame_tick  = 1'b0;
      player_lane = 2'($urandom_range(0, 3));  // must not affect this scan
      for (int k = 1; k <= 12; k++) begin
         @(negedge Clock);
         if (busy)      bmask |= (1 << (k - 1));
         if (collision) cmask |= (1 << (k - 1));
      end
      check({name, " busy_window"}, bmask, 32'h1FF);
      check({name, " collision_window"}, cmask, exp_hit ? (1 << 9) : 0);
      check({name, " hit_index"}, int'(hit_index), exp_idx);
      prev_idx = exp_idx;
   endtask

   task automatic count_pulses(input int cycles, output int pulses, output int busy_cyc);
      pulses = 0; busy_cyc = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge Clock);
         if (collision) pulses++;
         if (busy) busy_cyc++;
      end
   endtask

   typedef struct {
      string      name;
      bit         v;
      logic [1:0] l;
      int         y;
      int         plane;
      bit         exp_hit;
   } vec_t;

   vec_t vecs [$];

   initial begin
      bit h;
      int ix, p, b;

      vecs.push_back('{"y390",     1'b1, 2'd1, 390, 1, 1'b1});
      vecs.push_back('{"y381",     1'b1, 2'd1, 381, 1, 1'b1});
      vecs.push_back('{"y380",     1'b1, 2'd1, 380, 1, 1'b0});
      vecs.push_back('{"y419",     1'b1, 2'd1, 419, 1, 1'b1});
      vecs.push_back('{"y420",     1'b1, 2'd1, 420, 1, 1'b0});
      vecs.push_back('{"y511",     1'b1, 2'd1, 511, 1, 1'b0});
      vecs.push_back('{"lane3",    1'b1, 2'd3, 405, 3, 1'b1});
      vecs.push_back('{"lane_miss",1'b1, 2'd2, 405, 0, 1'b0});
      vecs.push_back('{"invalid",  1'b0, 2'd0, 405, 0, 1'b0});

      clear_mem();
      #12;
      @(negedge Clock);
      check("reset busy", int'(busy), 0);
      check("reset collision", int'(collision), 0);
      check("reset hit_index", int'(hit_index), 0);
      check("reset obs_addr", int'(obs_addr), 0);
      check("reset overrun", int'(scan_overrun), 0);
      Reset = 1'b0;

      scan_and_check("empty", 1, 1'b0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         clear_mem();
         mem_v[5] = vecs[i].v;
         mem_l[5] = vecs[i].l;
         mem_y[5] = 9'(vecs[i].y);
         scan_and_check(vecs[i].name, vecs[i].plane, vecs[i].exp_hit,
                        vecs[i].exp_hit ? 5 : prev_idx);
      end

      // Two hitting slots plus a decoy in another lane.
      clear_mem();
      mem_v[2] = 1; mem_l[2] = 0; mem_y[2] = 9'd400;
      mem_v[6] = 1; mem_l[6] = 0; mem_y[6] = 9'd410;
      mem_v[3] = 1; mem_l[3] = 2; mem_y[3] = 9'd400;
      scan_and_check("multi", 0, 1'b1, 2);
      clear_mem();
      mem_v[3] = 1; mem_l[3] = 2; mem_y[3] = 9'd400;
      scan_and_check("decoy", 0, 1'b0, prev_idx);

      for (int r = 0; r < 40; r++) begin
         int pl;
         for (int i = 0; i < N; i++) begin
            mem_v[i] = 1'($urandom_range(0, 1));
            mem_l[i] = 2'($urandom_range(0, 3));
            mem_y[i] = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(370, 430)) : 9'($urandom_range(0, 511));
         end
         pl = $urandom_range(0, 3);
         model(pl, h, ix);
         scan_and_check("random", pl, h, ix);
      end

      // Second tick while busy.
      clear_mem();
      mem_v[5] = 1; mem_l[5] = 1; mem_y[5] = 9'd390;
      @(posedge Clock); #1; player_lane = 1; frame_tick = 1;
      @(posedge Clock); #1; frame_tick = 0;
      repeat (3) @(posedge Clock);
      #1 frame_tick = 1;
      @(posedge Clock); #1 frame_tick = 0;
      count_pulses(12, p, b);
      check("overrun pulses", p, 1);
      check("overrun flag", int'(scan_overrun), 1);
      prev_idx = 5;
      scan_and_check("overrun sticky scan", 1, 1'b1, 5);
      check("overrun still set", int'(scan_overrun), 1);
      #2 Reset = 1; #1;
      check("overrun cleared", int'(scan_overrun), 0);
      @(posedge Clock); #1 Reset = 0;
      prev_idx = 0;

      // Establish hit_index=2, then abort a hit scan with freeze.
      clear_mem();
      mem_v[2] = 1; mem_l[2] = 1; mem_y[2] = 9'd400;
      scan_and_check("pre_freeze", 1, 1'b1, 2);
      clear_mem();
      mem_v[5] = 1; mem_l[5] = 1; mem_y[5] = 9'd390;
      @(posedge Clock); #1; player_lane = 1; frame_tick = 1;
      @(posedge Clock); #1; frame_tick = 0;
      repeat (4) @(posedge Clock);
      #1 freeze = 1;
      @(negedge Clock);
      check("freeze busy T+5", int'(busy), 1);
      @(negedge Clock);
      check("freeze busy T+6", int'(busy), 0);
      count_pulses(10, p, b);
      check("freeze pulses", p, 0);
      check("freeze hit_index", int'(hit_index), 2);
      @(posedge Clock); #1 frame_tick = 1;
      @(posedge Clock); #1 frame_tick = 0;
      count_pulses(12, p, b);
      check("frozen tick busy", b, 0);
      check("frozen tick pulses", p, 0);
      freeze = 0;

      // Asynchronous reset mid-scan.
      @(posedge Clock); #1 frame_tick = 1;
      @(posedge Clock); #1 frame_tick = 0;
      repeat (2) @(posedge Clock);
      #2 Reset = 1;
      #1;
      check("async busy", int'(busy), 0);
      check("async obs_addr", int'(obs_addr), 0);
      check("async hit_index", int'(hit_index), 0);
      @(posedge Clock); #1 Reset = 0;
      count_pulses(12, p, b);
      check("post reset pulses", p, 0);
      check("post reset busy", b, 0);
      prev_idx = 0;
      scan_and_check("resume", 1, 1'b1, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/lane_collision_detector.md
Name: lane_collision_detector

Overview:
- Sits directly upstream of the game-over latch.
- Once per video frame it scans every obstacle slot held by the obstacle manager and compares each active obstacle's lane and vertical extent against the player sprite.
- Drives a single-cycle `collision` pulse to the game-over latch, plus diagnostic outputs for the HUD and debug LEDs.

Parameters:
- NUM_OBS, 8, number of obstacle slots scanned per frame (power of two, ≥2)
- IDX_W, 3, width of slot index, = log2(NUM_OBS)
- Y_W, 9, width of vertical pixel coordinates (0..479)
- PLAYER_Y, 400, top row of player sprite (fixed)
- PLAYER_H, 20, player sprite height in rows
- OBS_H, 20, obstacle sprite height in rows

Ports:
- Clock  input  1  system clock
- Reset  input  1  asynchronous, active-high reset
- frame_tick  input  1  one-cycle pulse at start of vertical blanking
- freeze  input  1  game_over from latch; inhibits and aborts scanning
- player_lane  input  2  current player lane, 0..2
- obs_addr  output  IDX_W  slot index presented to obstacle manager read port
- obs_valid  input  1  slot active; 1-cycle read latency from obs_addr
- obs_lane  input  2  slot lane; 1-cycle read latency
- obs_y  input  Y_W  slot top row; 1-cycle read latency
- busy  output  1  scan in progress
- collision  output  1  one-cycle pulse; at least one hit this frame
- hit_index  output  IDX_W  lowest-numbered hitting slot of last hit scan
- scan_overrun  output  1  sticky: frame_tick arrived while busy

Behaviour:
- Clock and reset: one clock (Clock). Reset is asynchronous, active-high.
- Reset values: state IDLE, obs_addr 0, busy 0, collision 0, hit_index 0, scan_overrun 0, internal hit flag 0, latched lane 0.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - frame_tick=1 and freeze=0 → SCAN.
  - On that edge: obs_addr←0, lane_q←player_lane, hit flag cleared, busy←1.
  - frame_tick with freeze=1 is ignored.
- SCAN:
  - obs_addr increments by 1 each cycle.
  - Data returned for the address of the previous cycle is compared with a one-cycle delayed compare-enable.
  - Leaving SCAN when obs_addr = NUM_OBS-1 → DRAIN; obs_addr holds NUM_OBS-1, no wrap.
- DRAIN: compares the final slot's data, then → DONE.
- DONE:
  - collision = hit flag for exactly this cycle.
  - hit_index updated only if hit.
  - busy←0; → IDLE.
- Latency: tick sampled at edge T → addresses 0..N-1 driven in cycles T+1..T+N. Compares occur in T+2..T+N+1. collision high in cycle T+N+2. busy high T+1..T+N+1.
- Hit condition for a slot, evaluated with Y_W+1-bit arithmetic so there is no overflow:
  - obs_valid=1, and
  - obs_lane == lane_q, and
  - obs_y ≤ PLAYER_Y+PLAYER_H-1, and
  - obs_y+OBS_H-1 ≥ PLAYER_Y.
  - Boundary rows touching counts as a hit. obs_y near 511 must not wrap into a hit.
- Multiple hits: hit flag ORs across slots. hit_index captures the first (lowest) hitting slot only.
- player_lane is sampled once per scan. Changes mid-scan do not affect the current scan.
- frame_tick while busy: ignored, and scan_overrun←1. It stays 1 until Reset.
- freeze rising mid-scan (SCAN or DRAIN):
  - Next state IDLE, busy←0.
  - No collision pulse.
  - hit_index unchanged.
- freeze in DONE: collision still pulses, since the latch is already set and the pulse is harmless.
- collision never stays high for 2 consecutive cycles. A pulse occurs at most once per accepted frame_tick.
- Reset asserted mid-scan: all outputs return to reset values immediately (asynchronous). Scanning resumes only on the next frame_tick after deassertion.
- Lane value 3 is compared like any other value; no special case.

Test Plan:
- Reset, then a tick with all slots obs_valid=0 → busy high for 9 cycles; collision stays 0 at T+10; hit_index=0.
- player_lane=1, slot 5 {valid,1,obs_y=390}, tick → single collision pulse exactly at T+10; hit_index=5.
- Boundary cases, one slot, lane matched:
  - obs_y=381 (bottom row 400) → hit.
  - obs_y=380 → no hit.
  - obs_y=419 → hit.
  - obs_y=420 → no hit.
  - obs_y=511 → no hit.
- Slots 2 and 6 both hit → one pulse; hit_index=2. Slot 3 at the same y in lane 2 with player_lane=0 → no hit.
- Second frame_tick at T+4 → ignored; scan_overrun=1 and sticky; only one collision pulse. Reset → scan_overrun=0.
- Hit scan in progress, freeze raised at T+5 → busy=0 by T+6; no collision pulse. Ticks with freeze=1 → no scan. Reset asserted at T+3 → busy=0 and obs_addr=0 asynchronously.
